// File: rtl/pixel_word_packer.sv
// Packs a raster stream of RGB565 pixels into 128-bit words of eight lanes and
// queues them in a first-word-fall-through FIFO with frame bookkeeping.
module pixel_word_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned H_PIXELS   = 320
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [8:0]   h_count,
    input  logic [7:0]   v_count,
    input  logic         valid,
    input  logic         last,
    input  logic [15:0]  data,
    output logic [127:0] word_data,
    output logic [12:0]  word_addr,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         word_last,
    output logic         frame_done,
    output logic         overflow,
    output logic         partial
);

    localparam int unsigned WordsPerRow = H_PIXELS / 8;
    localparam int unsigned PtrW        = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [127:0] data;
        logic [12:0]  addr;
        logic         last;
    } word_t;

    typedef enum logic [1:0] {StIdle, StPacking, StDrain} state_e;

    state_e       state_q, state_d;
    logic [127:0] asm_data_q, asm_data_d;
    logic [7:0]   mask_q, mask_d;
    logic [12:0]  addr_q, addr_d;
    word_t        stg_q, stg_d, skid_q, skid_d;
    logic         stg_valid_q, stg_valid_d, skid_valid_q, skid_valid_d;
    logic         partial_q, partial_d, overflow_q, overflow_d;

    word_t           mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;

    logic [2:0]   lane;
    logic [12:0]  pix_addr, merged_addr;
    logic         disc, flush, eff_last;
    logic [127:0] base_data, merged_data;
    logic [7:0]   base_mask, merged_mask;
    word_t        pend_word, new_word;
    logic         pop, push, fifo_full;

    // Assembly register: merge the current pixel, detect flush and discontinuity.
    always_comb begin
        lane        = h_count[2:0];
        pix_addr    = 13'(v_count) * 13'(WordsPerRow) + 13'(h_count[8:3]);
        disc        = valid && (mask_q != 8'h00) && (pix_addr != addr_q);
        flush       = valid && ((lane == 3'd7) || last);
        eff_last    = last && (state_q != StDrain);
        base_data   = disc ? '0 : asm_data_q;
        base_mask   = disc ? '0 : mask_q;
        merged_data = base_data;
        merged_data[{lane, 4'b0000} +: 16] = data;
        merged_mask = base_mask | (8'd1 << lane);
        merged_addr = (base_mask == 8'h00) ? pix_addr : addr_q;

        pend_word.data = asm_data_q;
        pend_word.addr = addr_q;
        pend_word.last = 1'b0;
        new_word.data  = merged_data;
        new_word.addr  = merged_addr;
        new_word.last  = eff_last;

        asm_data_d = asm_data_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        if (valid) begin
            if (flush) begin
                asm_data_d = '0;
                mask_d     = '0;
            end else begin
                asm_data_d = merged_data;
                mask_d     = merged_mask;
                addr_d     = merged_addr;
            end
        end

        partial_d = partial_q | (disc && (mask_q != 8'hFF)) | (flush && (merged_mask != 8'hFF));
    end

    // Push stage: skid drains first, then the pending word, then the new word.
    // Two new words only arrive on a discontinuity, which needs a prior
    // non-flushing cycle, so the skid is always empty when both arrive.
    always_comb begin
        stg_valid_d  = 1'b0;
        stg_d        = '0;
        skid_valid_d = 1'b0;
        skid_d       = '0;
        if (skid_valid_q) begin
            stg_valid_d = 1'b1;
            stg_d       = skid_q;
        end
        if (disc) begin
            if (!stg_valid_d) begin
                stg_valid_d = 1'b1;
                stg_d       = pend_word;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = pend_word;
            end
        end
        if (flush) begin
            if (!stg_valid_d) begin
                stg_valid_d = 1'b1;
                stg_d       = new_word;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = new_word;
            end
        end
    end

    always_comb begin
        fifo_full  = (count_q == FullCount);
        word_valid = (count_q != '0);
        word_data  = word_valid ? mem_q[rd_ptr_q].data : '0;
        word_addr  = word_valid ? mem_q[rd_ptr_q].addr : '0;
        word_last  = word_valid && mem_q[rd_ptr_q].last;
        pop        = word_valid && word_ready;
        push       = stg_valid_q && (!fifo_full || pop);
        overflow_d = overflow_q | (stg_valid_q && fifo_full && !pop);
        frame_done = pop && word_last;
        overflow   = overflow_q;
        partial    = partial_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (valid) state_d = last ? StDrain : StPacking;
            StPacking: if (valid && last) state_d = StDrain;
            StDrain:   if (frame_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            asm_data_q   <= '0;
            mask_q       <= '0;
            addr_q       <= '0;
            stg_q        <= '0;
            stg_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            partial_q    <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            asm_data_q   <= asm_data_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            stg_q        <= stg_d;
            stg_valid_q  <= stg_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            partial_q    <= partial_d;
            overflow_q   <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= stg_q;
    end

endmodule

// File: doc/pixel_word_packer.md
PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: output word FIFO depth in entries; power of two, minimum 4.
REQ-002 Parameter H_PIXELS, default 320: pixels per row; a multiple of 8.
REQ-003 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 h_count  input  9  pixel column, 0..319.
REQ-006 v_count  input  8  pixel row, 0..179.
REQ-007 valid  input  1  pixel qualifier; the source has no backpressure.
REQ-008 last  input  1  the pixel is the final pixel of its frame; meaningful only with valid.
REQ-009 data  input  16  RGB565 pixel color.
REQ-010 word_data  output  128  eight packed pixels; lane n in bits [16n+15:16n].
REQ-011 word_addr  output  13  word index, v_count*40 + h_count[8:3].
REQ-012 word_valid  output  1  a word is presented.
REQ-013 word_ready  input  1  the sink accepts the word when word_valid and word_ready are both high.
REQ-014 word_last  output  1  the presented word holds the frame's last pixel.
REQ-015 frame_done  output  1  one-cycle pulse on acceptance of a word with word_last set.
REQ-016 overflow  output  1  sticky: a word was dropped because the FIFO was full.
REQ-017 partial  output  1  sticky: a word was emitted with one or more lanes unwritten.

Function
REQ-018 Packing: a valid pixel writes data into lane h_count[2:0] of the assembly register and sets that lane's bit in an 8-bit lane mask.
REQ-019 Word address capture: the lane-0 pixel, or the first pixel after a flush, latches the word address.
REQ-020 Flush trigger: a word flushes when a valid pixel has h_count[2:0]==7 or last==1.
REQ-021 Flush action: the flushed word, with that cycle's pixel included, is pushed to the FIFO on the next clock.
REQ-022 After a flush, the lane mask clears, and the assembly register is ready for a pixel on the following cycle.
REQ-023 Unwritten lanes in a flushed word are zero; a mask other than 8'hFF at flush sets partial.
REQ-024 Discontinuity: if the pixel's word address (v_count*40 + h_count[8:3]) differs from the latched address while the mask is nonzero, the pending word flushes first (partial set) and the new pixel starts a fresh word.
REQ-025 Discontinuity and end-of-word together: if the new pixel also triggers REQ-020, the pending word is pushed first and the new word one cycle later, held in a one-entry skid register.
REQ-026 FIFO is first-word-fall-through: with the FIFO empty, word_valid rises one cycle after the push cycle, i.e. two cycles after the lane-7 pixel.
REQ-027 Output stability: word_data, word_addr and word_last hold steady while word_valid is high and word_ready is low.
REQ-028 Push to a full FIFO: the word is dropped and overflow is set; the FIFO contents are unchanged.
REQ-029 Simultaneous push and pop on a full FIFO: both take effect, and the occupancy is unchanged.
REQ-030 Simultaneous push and pop on an empty FIFO: the pushed word is presented on the next cycle.
REQ-031 Pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth; the occupancy count is log2(FIFO_DEPTH)+1 bits.
REQ-032 Frame state machine, IDLE -> PACKING: on the first valid pixel.
REQ-033 Frame state machine, PACKING -> DRAIN: on a last pixel.
REQ-034 Frame state machine, DRAIN -> IDLE: when the word_last word is accepted, with frame_done pulsing in that same cycle.
REQ-035 In DRAIN, incoming valid pixels are still packed, but any pixel with last==1 does not set word_last again until IDLE is reached.

Reset
REQ-036 On rst high at a clock edge, all state clears: FIFO empty, lane mask 0, skid register empty, state IDLE.
REQ-037 Reset values: word_valid=0, word_last=0, frame_done=0, overflow=0, partial=0, word_data=0, word_addr=0.
REQ-038 Reset mid-frame discards the partial words and the FIFO contents, and no frame_done is issued.
REQ-039 Inputs are ignored during the reset cycle.

Verification
REQ-040 Full row: pixels h=0..319 at v=5, data=h, word_ready=1 -> 40 words at addr 200..239; word 200 = 0x0007_0006_..._0000; partial=0.
REQ-041 Full frame: 320x180 raster with last on (319,179), word_ready=1 -> 7200 words, final addr 7199 with word_last=1, frame_done pulses once.
REQ-042 Backpressure: word_ready=0 for 16 full words, then a 17th word -> overflow=1; then word_ready=1 -> exactly 16 words drain in order.
REQ-043 Gap: pixels h=0..3 at v=0, then h=16 at v=0 -> word addr 0 emitted with mask 0x0F (lanes 4..7 zero), partial=1; the new word starts at addr 2.
REQ-044 Short last word: last asserted on h=2, v=0 -> word addr 0 emitted with word_last=1 and lanes 3..7 zero; frame_done pulses on acceptance.
REQ-045 Reset mid-frame: rst asserted after 100 pixels -> word_valid=0 next cycle, no further words, overflow and partial are 0.
